// File: rtl/dac_pkg.sv
// Shared types and helpers for the two-channel DAC transmitter.
package dac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun
  } state_e;

  // Code for the DAC's zero point: only the MSB of a w-bit word set.
  function automatic logic [31:0] midscale(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Two's complement to offset binary is an MSB flip; offset binary passes through.
  function automatic logic [31:0] to_offset_bin(input logic [31:0] x, input int unsigned w,
                                                input bit twos);
    return twos ? (x ^ midscale(w)) : x;
  endfunction

endpackage

// File: rtl/two_ch_dac_tx_if.sv
// Sample-pair input stream: valid/ready handshake carrying one A and one B sample.
interface two_ch_dac_tx_if #(
  parameter int unsigned DATA_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ina_d;
  logic [DATA_W-1:0] inb_d;

  modport master (output in_valid, ina_d, inb_d, input in_ready);
  modport slave  (input in_valid, ina_d, inb_d, output in_ready);
endinterface

// File: rtl/pair_fifo.sv
// Synchronous FIFO holding sample pairs; extra pointer MSB separates full from empty.
module pair_fifo #(
  parameter int unsigned Width = 28,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/two_ch_dac_tx.sv
// Two-channel DAC transmitter: buffers sample pairs and paces them out at sys_clk/DIV.
module two_ch_dac_tx
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV        = 4,
  parameter int unsigned TWOS_COMP  = 0
) (
  input  logic                        sys_clk,
  input  logic                        reset_n,
  input  logic                        enable,
  two_ch_dac_tx_if.slave              in_bus,
  output logic [DATA_W-1:0]           da_d,
  output logic [DATA_W-1:0]           db_d,
  output logic                        dac_clk,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  input  logic                        clr_underrun
);
  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] Mid = DATA_W'(midscale(DATA_W));

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] dac_a_q, dac_a_d, dac_b_q, dac_b_d;
  logic              dac_clk_q, dac_clk_d;
  logic              underrun_q, underrun_d;
  logic              ready_q;
  logic              full, empty, push, pop, tick;
  logic [2*DATA_W-1:0] wdata, rdata;

  // ready_q keeps in_ready low while in reset and releases it on the first edge after.
  assign in_bus.in_ready = ready_q && !full;
  assign push = in_bus.in_valid && in_bus.in_ready && enable;
  assign tick = (state_q == StRun) && (cnt_q == '0);
  assign pop  = tick && enable && !empty;

  assign wdata = {DATA_W'(to_offset_bin(32'(in_bus.inb_d), DATA_W, TWOS_COMP != 0)),
                  DATA_W'(to_offset_bin(32'(in_bus.ina_d), DATA_W, TWOS_COMP != 0))};

  pair_fifo #(
    .Width (2 * DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .flush (!enable),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Next-state: pacing FSM, divider, output samples, DAC strobe, sticky underrun.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dac_a_d    = dac_a_q;
    dac_b_d    = dac_b_q;
    dac_clk_d  = dac_clk_q;
    underrun_d = underrun_q && !clr_underrun;
    if (!enable) begin
      state_d   = StIdle;
      cnt_d     = '0;
      dac_a_d   = Mid;
      dac_b_d   = Mid;
      dac_clk_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StPrime;
          cnt_d     = '0;
          dac_a_d   = Mid;
          dac_b_d   = Mid;
          dac_clk_d = 1'b0;
        end
        StPrime: begin
          if (level >= LW'(FIFO_DEPTH / 2)) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          cnt_d     = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
          // Strobe rises half a sample period after the data changes.
          dac_clk_d = (cnt_q >= CW'(DIV / 2));
          if (tick) begin
            if (!empty) {dac_b_d, dac_a_d} = rdata;
            else        underrun_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dac_a_q    <= Mid;
      dac_b_q    <= Mid;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dac_a_q    <= dac_a_d;
      dac_b_q    <= dac_b_d;
      dac_clk_q  <= dac_clk_d;
      underrun_q <= underrun_d;
      ready_q    <= 1'b1;
    end
  end

  assign da_d     = dac_a_q;
  assign db_d     = dac_b_q;
  assign dac_clk  = dac_clk_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_two_ch_dac_tx.sv
// Bench for two_ch_dac_tx: offset-binary and two's-complement instances share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_two_ch_dac_tx;
  localparam int DW    = 14;
  localparam int Depth = 4;
  localparam int Div   = 4;
  localparam logic [13:0] Mid = 14'h2000;

  typedef struct packed {
    logic [13:0] a;
    logic [13:0] b;
  } pair_t;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        in_valid;
  logic        clr_underrun;
  logic [13:0] ina_d;
  logic [13:0] inb_d;

  logic [13:0] da0, db0, da1, db1;
  logic        dclk0, dclk1, und0, und1;
  logic [2:0]  lvl0, lvl1;

  two_ch_dac_tx_if #(.DATA_W(DW)) bus0 ();
  two_ch_dac_tx_if #(.DATA_W(DW)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.ina_d    = ina_d;
  assign bus0.inb_d    = inb_d;
  assign bus1.in_valid = in_valid;
  assign bus1.ina_d    = ina_d;
  assign bus1.inb_d    = inb_d;

  two_ch_dac_tx #(
    .DATA_W(DW), .FIFO_DEPTH(Depth), .DIV(Div), .TWOS_COMP(0)
  ) dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .in_bus(bus0),
    .da_d(da0), .db_d(db0), .dac_clk(dclk0), .level(lvl0), .underrun(und0),
    .clr_underrun(clr_underrun)
  );

  two_ch_dac_tx #(
    .DATA_W(DW), .FIFO_DEPTH(Depth), .DIV(Div), .TWOS_COMP(1)
  ) dut1 (
    .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .in_bus(bus1),
    .da_d(da1), .db_d(db1), .dac_clk(dclk1), .level(lvl1), .underrun(und1),
    .clr_underrun(clr_underrun)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state.
  pair_t       q[$];
  int          m_state;  // 0 idle, 1 prime, 2 run
  int          m_cyc;    // cycles spent in run
  bit          m_live;
  bit          m_clk;
  bit          m_und;
  logic [13:0] m_a0, m_b0, m_a1, m_b1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
  endtask

  function automatic bit m_ready();
    return m_live && (q.size() < Depth);
  endfunction

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_cyc   = 0;
    m_live  = 1'b0;
    m_clk   = 1'b0;
    m_und   = 1'b0;
    m_a0 = Mid; m_b0 = Mid; m_a1 = Mid; m_b1 = Mid;
  endtask

  task automatic model_step();
    bit    push, tick, pop;
    int    lvl;
    pair_t head;
    push = in_valid && m_ready() && enable;
    tick = (m_state == 2) && ((m_cyc % Div) == 0);
    pop  = tick && enable && (q.size() > 0);
    lvl  = q.size();
    head = pop ? q[0] : '0;
    if (clr_underrun) m_und = 1'b0;
    if (!enable) begin
      q.delete();
      m_state = 0;
      m_cyc   = 0;
      m_clk   = 1'b0;
      m_a0 = Mid; m_b0 = Mid; m_a1 = Mid; m_b1 = Mid;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({ina_d, inb_d});
      case (m_state)
        0: m_state = 1;
        1: if (lvl >= Depth / 2) begin
             m_state = 2;
             m_cyc   = 0;
           end
        default: begin
          m_clk = (m_cyc % Div) >= (Div / 2);
          if (tick) begin
            if (pop) begin
              m_a0 = head.a;       m_b0 = head.b;
              m_a1 = head.a ^ Mid; m_b1 = head.b ^ Mid;
            end else begin
              m_und = 1'b1;
            end
          end
          m_cyc++;
        end
      endcase
    end
    m_live = 1'b1;
  endtask

  task automatic check_all();
    check("da0",    32'(da0),            32'(m_a0));
    check("db0",    32'(db0),            32'(m_b0));
    check("da1",    32'(da1),            32'(m_a1));
    check("db1",    32'(db1),            32'(m_b1));
    check("dclk0",  32'(dclk0),          32'(m_clk));
    check("dclk1",  32'(dclk1),          32'(m_clk));
    check("lvl0",   32'(lvl0),           32'(q.size()));
    check("lvl1",   32'(lvl1),           32'(q.size()));
    check("rdy0",   32'(bus0.in_ready),  32'(m_ready()));
    check("rdy1",   32'(bus1.in_ready),  32'(m_ready()));
    check("und0",   32'(und0),           32'(m_und));
    check("und1",   32'(und1),           32'(m_und));
  endtask

  // One clock: drive inputs at the falling edge, advance model at the rising edge,
  // compare at the next falling edge.
  task automatic step(input bit v, input logic [13:0] a, input logic [13:0] b, input bit en,
                      input bit clr);
    in_valid = v; ina_d = a; inb_d = b; enable = en; clr_underrun = clr;
    @(posedge sys_clk);
    if (reset_n) model_step();
    @(negedge sys_clk);
    check_all();
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge sys_clk);
    check_all();
    reset_n = 1'b1;
  endtask

  int dens;

  initial begin
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; clr_underrun = 1'b0;
    ina_d = '0; inb_d = '0;
    model_reset();
    repeat (2) begin
      @(negedge sys_clk);
      check_all();
    end
    reset_n = 1'b1;
    repeat (2) step(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);

    // Prime with two pairs, then starve into underrun.
    step(1'b1, 14'h0100, 14'h3F00, 1'b1, 1'b0);
    step(1'b1, 14'h0200, 14'h3E00, 1'b1, 1'b0);
    repeat (14) step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0);
    // Clear requested every cycle: holds on tick underruns, clears otherwise.
    repeat (6) step(1'b0, 14'h0, 14'h0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0);

    // Two's-complement extremes.
    repeat (2) step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    step(1'b1, 14'h3FFF, 14'h0000, 1'b1, 1'b0);
    step(1'b1, 14'h2000, 14'h1FFF, 1'b1, 1'b0);
    repeat (10) step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0);

    // Continuous valid: fills to full, then back-pressure until ticks drain.
    repeat (2) step(1'b0, 14'h0, 14'h0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 14'(i * 3 + 1), 14'(i * 5 + 2), 1'b1, 1'b0);
    step(1'b0, 14'h0, 14'h0, 1'b1, 1'b0);
    // Disable mid-run with a partly full FIFO, then re-enable and reset mid-run.
    step(1'b0, 14'h0, 14'h0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 14'(i * 7), 14'(i * 11), 1'b1, 1'b0);
    async_reset();

    // Randomized segments of varying push density.
    for (int seg = 0; seg < 12; seg++) begin
      dens = int'($urandom_range(0, 100));
      for (int i = 0; i < 50; i++) begin
        step(int'($urandom_range(0, 99)) < dens, 14'($urandom), 14'($urandom),
             $urandom_range(0, 59) != 0, $urandom_range(0, 7) == 0);
      end
      if (seg % 4 == 3) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
